// File: rtl/gamesys_mem_pkg.sv
// Shared definitions for the GameSystem on-chip memory blocks.
//   state_t       : controller state (array clear in progress / ready)
//   READ_LAT_MIN  : shortest supported read latency in cycles
//   READ_LAT_MAX  : longest supported read latency in cycles
//   nbytes()      : number of byte lanes in a word of the given width
package gamesys_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/gamesys_tdp_ram_be.sv
// True-dual-port byte-enabled RAM with registered, read-first read ports.
// Ports A and B are symmetric:
//   clk             : clock
//   en              : clock enable; low freezes the array and both read registers
//   x_addr          : word address
//   x_we / x_be     : write strobe and byte-lane enables
//   x_wdata         : write data
//   x_re            : load the read register with the word at x_addr
//   x_rdata         : registered read data (old contents on a same-cycle write)
// When the two ports write the same lane of the same word in one cycle, port B
// takes effect; callers that need a different priority mask x_be beforehand.
// INIT_FILE names a memory image attached to the array for configuration-time
// preload; an empty name leaves the array unloaded.
module gamesys_tdp_ram_be
  import gamesys_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [ADDR_W-1:0]            a_addr,
  input  logic                         a_we,
  input  logic [nbytes(DATA_W)-1:0]    a_be,
  input  logic [DATA_W-1:0]            a_wdata,
  input  logic                         a_re,
  output logic [DATA_W-1:0]            a_rdata,
  input  logic [ADDR_W-1:0]            b_addr,
  input  logic                         b_we,
  input  logic [nbytes(DATA_W)-1:0]    b_be,
  input  logic [DATA_W-1:0]            b_wdata,
  input  logic                         b_re,
  output logic [DATA_W-1:0]            b_rdata
);

  localparam int NB    = nbytes(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  if (INIT_FILE != "") begin : g_image
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (en) begin
        if (a_re) a_rdata <= mem[a_addr];
        if (b_re) b_rdata <= mem[b_addr];
        for (int i = 0; i < NB; i++) begin
          if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
          if (b_we && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
        end
      end
    end
  end else begin : g_blank
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (en) begin
        if (a_re) a_rdata <= mem[a_addr];
        if (b_re) b_rdata <= mem[b_addr];
        for (int i = 0; i < NB; i++) begin
          if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
          if (b_we && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/gamesys_onchip_ram_dp.sv
// Dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) on one shared
// true-dual-port byte-enabled array.
//   clk, reset, clken            : clock, sync active-high reset, global enable
//   sN_address/chipselect/read/write/byteenable/writedata : slave commands
//   sN_readdata, sN_readdatavalid: read results, READ_LATENCY enabled cycles
//                                  after accept, in order, one strobe per read
//   sN_waitrequest               : command not accepted (clearing, stalled, reset)
//   init_done                    : array usable
// s1 owns RAM port A (shared with the clear engine), s2 owns port B. On a
// same-word dual write s1 lanes win; a read colliding with the other port's
// write returns the old word.
module gamesys_onchip_ram_dp
  import gamesys_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter     INIT_FILE      = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic [ADDR_WIDTH-1:0]     s1_address,
  input  logic                      s1_chipselect,
  input  logic                      s1_read,
  input  logic                      s1_write,
  input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
  input  logic [DATA_WIDTH-1:0]     s1_writedata,
  output logic [DATA_WIDTH-1:0]     s1_readdata,
  output logic                      s1_readdatavalid,
  output logic                      s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]     s2_address,
  input  logic                      s2_chipselect,
  input  logic                      s2_read,
  input  logic                      s2_write,
  input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
  input  logic [DATA_WIDTH-1:0]     s2_writedata,
  output logic [DATA_WIDTH-1:0]     s2_readdata,
  output logic                      s2_readdatavalid,
  output logic                      s2_waitrequest,
  output logic                      init_done
);

  // Out-of-range latencies are pulled to the nearest supported value.
  localparam int LAT = (READ_LATENCY > READ_LAT_MAX) ? READ_LAT_MAX :
                       (READ_LATENCY < READ_LAT_MIN) ? READ_LAT_MIN : READ_LATENCY;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clear_addr;
  logic                    ready;
  logic                    waitrequest;
  logic                    clearing;

  // Clear engine: one zero word per enabled cycle, last address hands over.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clear_addr <= '0;
    end else if (clken && state == ST_CLEAR) begin
      clear_addr <= clear_addr + 1'b1;
      if (&clear_addr) state <= ST_READY;
    end
  end

  // Reset is folded in so nothing is accepted while reset is still asserted.
  assign ready       = (state == ST_READY) && !reset;
  assign waitrequest = !ready || !clken;
  assign init_done   = ready;
  assign clearing    = (state == ST_CLEAR) && !reset;

  assign s1_waitrequest = waitrequest;
  assign s2_waitrequest = waitrequest;

  logic s1_wr_acc, s1_rd_acc, s2_wr_acc, s2_rd_acc;

  // A simultaneous read+write is treated as a write only.
  assign s1_wr_acc = s1_chipselect && s1_write && !waitrequest;
  assign s1_rd_acc = s1_chipselect && s1_read && !s1_write && !waitrequest;
  assign s2_wr_acc = s2_chipselect && s2_write && !waitrequest;
  assign s2_rd_acc = s2_chipselect && s2_read && !s2_write && !waitrequest;

  logic [DATA_WIDTH/8-1:0] a_be, b_be, s1_lane_block;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH-1:0]   a_wdata;
  logic                    a_we;

  assign a_we    = clearing || s1_wr_acc;
  assign a_addr  = clearing ? clear_addr : s1_address;
  assign a_be    = clearing ? '1 : s1_byteenable;
  assign a_wdata = clearing ? '0 : s1_writedata;

  // s1 has priority on lanes both ports write to the same word.
  assign s1_lane_block = (s1_wr_acc && (s1_address == s2_address)) ? s1_byteenable : '0;
  assign b_be          = s2_byteenable & ~s1_lane_block;

  logic [1:0]            rd_acc;
  logic [DATA_WIDTH-1:0] ram_q [2];
  logic [1:0]            rdv;
  logic [DATA_WIDTH-1:0] rdata [2];

  assign rd_acc = {s2_rd_acc, s1_rd_acc};

  gamesys_tdp_ram_be #(
    .DATA_W    (DATA_WIDTH),
    .ADDR_W    (ADDR_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .en      (clken),
    .a_addr  (a_addr),
    .a_we    (a_we),
    .a_be    (a_be),
    .a_wdata (a_wdata),
    .a_re    (rd_acc[0]),
    .a_rdata (ram_q[0]),
    .b_addr  (s2_address),
    .b_we    (s2_wr_acc),
    .b_be    (b_be),
    .b_wdata (s2_writedata),
    .b_re    (rd_acc[1]),
    .b_rdata (ram_q[1])
  );

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  vld_p0;
    logic                  vld_out;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] hold_q;

    // Stage p0: RAM read register, valid follows the accepted read.
    always_ff @(posedge clk) begin
      if (reset)      vld_p0 <= 1'b0;
      else if (clken) vld_p0 <= rd_acc[p];
    end

    if (LAT == READ_LAT_MAX) begin : g_lat2
      logic                  vld_p1;
      logic [DATA_WIDTH-1:0] data_p1;

      // Stage p1: extra output register.
      always_ff @(posedge clk) begin
        if (reset)      vld_p1 <= 1'b0;
        else if (clken) vld_p1 <= vld_p0;
      end

      always_ff @(posedge clk) begin
        if (clken && vld_p0) data_p1 <= ram_q[p];
      end

      assign vld_out = vld_p1;
      assign out_q   = data_p1;
    end else begin : g_lat1
      assign vld_out = vld_p0;
      assign out_q   = ram_q[p];
    end

    // A strobe due during a stall is withheld and delivered once clken returns.
    assign rdv[p]   = vld_out && clken;
    assign rdata[p] = rdv[p] ? out_q : hold_q;

    // Output hold: readdata only moves on a delivered strobe.
    always_ff @(posedge clk) begin
      if (reset) hold_q <= '0;
      else       hold_q <= rdata[p];
    end
  end

  assign s1_readdatavalid = rdv[0];
  assign s2_readdatavalid = rdv[1];
  assign s1_readdata      = rdata[0];
  assign s2_readdata      = rdata[1];

endmodule

// File: tb/tb_gamesys_onchip_ram_dp.sv
module tb_gamesys_onchip_ram_dp;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clken = 1'b1;

  logic [AW-1:0] s1_address = '0, s2_address = '0;
  logic          s1_chipselect = 1'b0, s2_chipselect = 1'b0;
  logic          s1_read = 1'b0, s2_read = 1'b0;
  logic          s1_write = 1'b0, s2_write = 1'b0;
  logic [3:0]    s1_byteenable = '0, s2_byteenable = '0;
  logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;

  // u0: READ_LATENCY=1, u1: READ_LATENCY=2; same stimulus to both.
  logic [DW-1:0] u0_s1_readdata, u0_s2_readdata, u1_s1_readdata, u1_s2_readdata;
  logic u0_s1_readdatavalid, u0_s2_readdatavalid, u1_s1_readdatavalid, u1_s2_readdatavalid;
  logic u0_s1_waitrequest, u0_s2_waitrequest, u1_s1_waitrequest, u1_s2_waitrequest;
  logic u0_init_done, u1_init_done;

  always #5 clk = ~clk;

  gamesys_onchip_ram_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) u0 (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(u0_s1_readdata), .s1_readdatavalid(u0_s1_readdatavalid),
    .s1_waitrequest(u0_s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(u0_s2_readdata), .s2_readdatavalid(u0_s2_readdatavalid),
    .s2_waitrequest(u0_s2_waitrequest),
    .init_done(u0_init_done)
  );

  gamesys_onchip_ram_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) u1 (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(u1_s1_readdata), .s1_readdatavalid(u1_s1_readdatavalid),
    .s1_waitrequest(u1_s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(u1_s2_readdata), .s2_readdatavalid(u1_s2_readdatavalid),
    .s2_waitrequest(u1_s2_waitrequest),
    .init_done(u1_init_done)
  );

  // Index k = dut*2 + port.
  logic          rdv_a [4];
  logic [DW-1:0] rdd_a [4];
  logic          wr_a  [4];
  assign rdv_a[0] = u0_s1_readdatavalid;  assign rdd_a[0] = u0_s1_readdata;  assign wr_a[0] = u0_s1_waitrequest;
  assign rdv_a[1] = u0_s2_readdatavalid;  assign rdd_a[1] = u0_s2_readdata;  assign wr_a[1] = u0_s2_waitrequest;
  assign rdv_a[2] = u1_s1_readdatavalid;  assign rdd_a[2] = u1_s1_readdata;  assign wr_a[2] = u1_s1_waitrequest;
  assign rdv_a[3] = u1_s2_readdatavalid;  assign rdd_a[3] = u1_s2_readdata;  assign wr_a[3] = u1_s2_waitrequest;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Scoreboard: expected read data and the enabled-edge count at which it is due.
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t          sbq [4][$];
  logic [31:0]   m_mem [DEPTH];
  bit            m_ready = 1'b0;
  logic [AW-1:0] m_caddr = '0;
  int            en_cnt = 0;
  bit            started = 1'b0;
  logic [31:0]   old1, old2;
  logic [31:0]   last [4];
  exp_t          e;

  task automatic push_rd(input int p, input logic [31:0] d);
    sbq[p].push_back('{data: d, due: en_cnt});
    sbq[2+p].push_back('{data: d, due: en_cnt + 1});
  endtask

  task automatic wlanes(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    for (int i = 0; i < 4; i++)
      if (be[i]) m_mem[a][i*8 +: 8] = d[i*8 +: 8];
  endtask

  // Reference model, evaluated at each active edge.
  always @(posedge clk) begin
    if (reset) begin
      m_ready = 1'b0;
      m_caddr = '0;
      for (int k = 0; k < 4; k++) sbq[k].delete();
    end else if (clken) begin
      en_cnt++;
      if (!m_ready) begin
        m_mem[m_caddr] = '0;
        if (m_caddr == AW'(DEPTH - 1)) m_ready = 1'b1;
        m_caddr++;
      end else begin
        old1 = m_mem[s1_address];
        old2 = m_mem[s2_address];
        if (s1_chipselect && s1_read && !s1_write) push_rd(0, old1);
        if (s2_chipselect && s2_read && !s2_write) push_rd(1, old2);
        if (s2_chipselect && s2_write) wlanes(s2_address, s2_byteenable, s2_writedata);
        if (s1_chipselect && s1_write) wlanes(s1_address, s1_byteenable, s1_writedata);
      end
    end
  end

  // Monitor on the falling edge.
  always @(negedge clk) begin
    if (started && !reset) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("waitrequest[%0d]", k), 32'(wr_a[k]), 32'(!m_ready || !clken));
      chk("init_done_u0", 32'(u0_init_done), 32'(m_ready));
      chk("init_done_u1", 32'(u1_init_done), 32'(m_ready));
      for (int k = 0; k < 4; k++) begin
        if (!clken) chk($sformatf("stall_vld[%0d]", k), 32'(rdv_a[k]), 0);
        if (rdv_a[k]) begin
          if (sbq[k].size() == 0) begin
            chk($sformatf("spurious_vld[%0d]", k), 1, 0);
          end else begin
            e = sbq[k].pop_front();
            chk($sformatf("rdata[%0d]", k), rdd_a[k], e.data);
            chk($sformatf("latency[%0d]", k), en_cnt, e.due);
          end
          last[k] = rdd_a[k];
        end else begin
          chk($sformatf("hold[%0d]", k), rdd_a[k], last[k]);
          if (clken && sbq[k].size() > 0 && en_cnt >= sbq[k][0].due) begin
            chk($sformatf("missing_vld[%0d]", k), 0, 1);
            void'(sbq[k].pop_front());
          end
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) last[k] = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd1(input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
    s1_address = a; s1_byteenable = be; s1_writedata = d;
  endtask

  task automatic cmd2(input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
    s2_address = a; s2_byteenable = be; s2_writedata = d;
  endtask

  task automatic idle();
    cmd1(0, 0, '0, '0, '0);
    cmd2(0, 0, '0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up reset, commands held throughout the clear.
    reset = 1'b1;
    tick(); tick();
    started = 1'b1;
    reset = 1'b0;
    cmd1(1, 0, 4'd3, 4'hF, '0);
    cmd2(0, 1, 4'd7, 4'hF, 32'h5555_5555);
    repeat (16) tick();
    idle();
    chk("init_done_after_clear", 32'(u0_init_done), 1);
    chk("waitreq_after_clear", 32'(u1_s2_waitrequest), 0);

    // Every address reads zero, streamed on both ports.
    for (int i = 0; i < DEPTH; i++) begin
      cmd1(1, 0, AW'(i), '0, '0);
      cmd2(1, 0, AW'(DEPTH - 1 - i), '0, '0);
      tick();
    end
    idle();
    repeat (3) tick();

    // Byte-lane write over an existing word.
    cmd2(0, 1, 4'd5, 4'hF, 32'h1122_3344); tick();
    cmd2(0, 0, '0, '0, '0);
    cmd1(0, 1, 4'd5, 4'b0101, 32'hAABB_CCDD); tick();
    cmd1(0, 0, '0, '0, '0);
    cmd2(1, 0, 4'd5, '0, '0); tick();
    idle();
    repeat (3) tick();

    // Distinct words then back-to-back reads on both ports.
    for (int i = 0; i < 4; i++) begin
      cmd1(0, 1, AW'(i), 4'hF, 32'hA000_0000 + 32'(i) * 32'h0101_0101);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      cmd1(1, 0, AW'(i), '0, '0);
      cmd2(1, 0, AW'(3 - i), '0, '0);
      tick();
    end
    idle();
    repeat (3) tick();

    // Read and write together: write only, no strobe.
    cmd1(1, 1, 4'd6, 4'hF, 32'h6666_6666); tick();
    cmd1(1, 0, 4'd6, '0, '0); tick();
    idle();
    repeat (3) tick();

    // Dual-write collision and read/write collisions.
    cmd1(0, 1, 4'd9, 4'hF, 32'hCAFE_BABE); tick();
    cmd1(0, 1, 4'd9, 4'b1100, 32'hFFFF_0000);
    cmd2(0, 1, 4'd9, 4'b1111, 32'h1234_5678); tick();
    idle();
    cmd1(1, 0, 4'd9, '0, '0); tick();
    cmd1(0, 1, 4'd9, 4'hF, 32'h0BAD_F00D);
    cmd2(1, 0, 4'd9, '0, '0); tick();
    cmd1(1, 0, 4'd9, '0, '0);
    cmd2(0, 1, 4'd9, 4'hF, 32'h7777_8888); tick();
    cmd1(0, 0, '0, '0, '0);
    cmd2(1, 0, 4'd9, '0, '0); tick();
    idle();
    repeat (3) tick();

    // Stall one cycle after a read accept; requests during the stall are refused.
    cmd1(1, 0, 4'd5, '0, '0); tick();
    idle();
    cmd2(1, 0, 4'd2, '0, '0);
    clken = 1'b0;
    repeat (3) tick();
    idle();
    clken = 1'b1;
    repeat (4) tick();

    // Reset in the middle of a clear; commands held throughout.
    cmd1(0, 1, 4'd1, 4'hF, 32'hDEAD_BEEF);
    cmd2(1, 0, 4'd9, '0, '0);
    reset = 1'b1; tick();
    reset = 1'b0;
    repeat (7) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    repeat (15) tick();
    idle();
    tick();
    chk("init_done_after_reclear", 32'(u1_init_done), 1);
    for (int i = 0; i < DEPTH; i++) begin
      cmd1(1, 0, AW'(i), '0, '0);
      cmd2(1, 0, AW'(i), '0, '0);
      tick();
    end
    idle();
    repeat (5) tick();

    for (int k = 0; k < 4; k++)
      chk($sformatf("drain[%0d]", k), sbq[k].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
